fifo_axi_wr_master: RTL

//  Downstream consumer of the 128-bit write FIFO: pops FIFO entries and issues them as
//  AXI4 INCR write bursts (AW/W/B channels) to a contiguous, wrapping address region.

---
 rtl/fifo_axi_wr_master.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_axi_wr_master.sv
// Drains the 128-bit write FIFO into fixed-length AXI4 INCR write bursts,
// one burst outstanding, walking a wrapping address region.
module fifo_axi_wr_master #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       BURST_LEN    = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter logic [ADDR_W-1:0] REGION_BYTES = 'h1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              fifo_rd_en,
    input  logic              fifo_empty,
    input  logic [127:0]      fifo_rd_data,
    output logic [ADDR_W-1:0] awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [127:0]      wdata,
    output logic [15:0]       wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic              burst_done,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    localparam logic [8:0]        BEATS       = 9'(BURST_LEN);
    localparam logic [8:0]        LAST_BEAT   = 9'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 16);
    localparam logic [ADDR_W-1:0] REGION_END  = BASE_ADDR + REGION_BYTES;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  awaddr_q, awaddr_d;
    logic [8:0]         popped_q, popped_d;
    logic [8:0]         sent_q, sent_d;
    logic               pend_q, pend_d;
    logic               hold_full_q, hold_full_d;
    logic [127:0]       wdata_q, wdata_d;
    logic               err_q, err_d;

    logic               w_fire;
    logic               b_fire;
    logic               resp_err;

    assign awlen    = 8'(BURST_LEN - 1);
    assign awsize   = 3'b100;
    assign awburst  = 2'b01;
    assign wstrb    = 16'hFFFF;
    assign awaddr   = awaddr_q;
    assign awvalid  = (state_q == ADDR);
    assign bready   = (state_q == RESP);

    // The holding register counts as full from the cycle the popped word is on
    // fifo_rd_data; that word is shown directly and captured for later stalls.
    assign wvalid   = hold_full_q;
    assign wdata    = pend_q ? fifo_rd_data : wdata_q;
    assign wlast    = hold_full_q && (sent_q == LAST_BEAT);
    assign w_fire   = hold_full_q && wready;
    assign b_fire   = (state_q == RESP) && bvalid;
    assign resp_err = b_fire && (bresp != 2'b00);

    assign burst_done = b_fire;
    assign err        = err_q || resp_err;

    // A pop issued last cycle has already landed in the holding register, so
    // the full/drain condition alone keeps at most one word in flight.
    assign fifo_rd_en = (state_q == DATA) && !fifo_empty && (popped_q < BEATS) &&
                        (!hold_full_q || w_fire);

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        popped_d    = popped_q;
        sent_d      = sent_q;
        hold_full_d = hold_full_q;
        wdata_d     = wdata_q;
        pend_d      = fifo_rd_en;
        err_d       = err;

        if (pend_q) begin
            wdata_d = fifo_rd_data;
        end

        if (fifo_rd_en) begin
            hold_full_d = 1'b1;
            popped_d    = popped_q + 9'd1;
        end else if (w_fire) begin
            hold_full_d = 1'b0;
        end

        if (w_fire) begin
            sent_d = sent_q + 9'd1;
        end

        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (awready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_fire && wlast) begin
                    state_d  = RESP;
                    popped_d = '0;
                    sent_d   = '0;
                end
            end
            RESP: begin
                if (bvalid) begin
                    state_d = IDLE;
                    if (awaddr_q + BURST_BYTES == REGION_END) begin
                        awaddr_d = BASE_ADDR;
                    end else begin
                        awaddr_d = awaddr_q + BURST_BYTES;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            awaddr_q    <= BASE_ADDR;
            popped_q    <= '0;
            sent_q      <= '0;
            pend_q      <= 1'b0;
            hold_full_q <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            awaddr_q    <= awaddr_d;
            popped_q    <= popped_d;
            sent_q      <= sent_d;
            pend_q      <= pend_d;
            hold_full_q <= hold_full_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
        end
    end

endmodule
